// File: rtl/seq_player_pkg.sv
// Shared types and sizes for the sequence player and its register-file port.
package seq_pkg;

   localparam int unsigned SEQ_DEPTH = 16;
   localparam int unsigned SEQ_W     = 3;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned LEN_W     = 5;

   typedef enum logic [1:0] {IDLE, FETCH, ON, OFF} play_state_t;
   typedef logic [SEQ_W-1:0] symbol_t;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(SEQ_DEPTH)) ? LEN_W'(SEQ_DEPTH) : len;
   endfunction

endpackage

// File: rtl/seq_player_if.sv
// Control, register-file read port and display outputs of the sequence player.
interface seq_player_if;
   import seq_pkg::*;

   logic             start;
   logic             stop;
   logic [LEN_W-1:0] length;
   logic [IDX_W-1:0] rd_sel;
   symbol_t          rd_data;
   logic             step_valid;
   symbol_t          step_value;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, length, rd_data,
      input  rd_sel, step_valid, step_value, busy, done
   );

   modport slave (
      input  start, stop, length, rd_data,
      output rd_sel, step_valid, step_value, busy, done
   );

endinterface

// File: rtl/seq_player_phase_timer.sv
// Loadable down-counter shared by the ON and OFF phases; parks at zero.
module phase_timer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/seq_player.sv
// Plays stored symbols 0..len-1 from the sequence register file, each shown for
// ON_CYCLES followed by an OFF_CYCLES blank gap.
module seq_player
   import seq_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = 4_000_000,
   parameter int unsigned OFF_CYCLES = 1_000_000
) (
   input logic         clk,
   input logic         rst,
   seq_player_if.slave bus
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   // Keep at least one bit so single-cycle phases still build.
   localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   play_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] rd_sel_q, rd_sel_d;
   logic             valid_q, valid_d;
   symbol_t          value_q, value_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic               t_load;
   logic [TIMER_W-1:0] t_value;
   logic               t_zero;
   logic               last_step;

   phase_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (t_load),
      .load_value (t_value),
      .zero       (t_zero)
   );

   assign last_step = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      rd_sel_d = rd_sel_q;
      valid_d  = valid_q;
      value_d  = value_q;
      done_d   = 1'b0;
      t_load   = 1'b0;
      t_value  = '0;

      if (bus.stop) begin
         // Abort wins over everything; rd_sel intentionally keeps its last value.
         state_d = IDLE;
         valid_d = 1'b0;
         value_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  len_d = clamp_len(bus.length);
                  idx_d = '0;
                  if (clamp_len(bus.length) == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d  = FETCH;
                     rd_sel_d = '0;
                  end
               end
            end
            FETCH: begin
               value_d = bus.rd_data;
               valid_d = 1'b1;
               state_d = ON;
               t_load  = 1'b1;
               t_value = TIMER_W'(ON_CYCLES - 1);
            end
            ON: begin
               if (t_zero) begin
                  state_d = OFF;
                  valid_d = 1'b0;
                  value_d = '0;
                  t_load  = 1'b1;
                  t_value = TIMER_W'(OFF_CYCLES - 1);
               end
            end
            OFF: begin
               if (t_zero) begin
                  if (last_step) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d    = idx_q + IDX_W'(1);
                     rd_sel_d = idx_q + IDX_W'(1);
                     state_d  = FETCH;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         rd_sel_q <= '0;
         valid_q  <= 1'b0;
         value_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         rd_sel_q <= rd_sel_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.rd_sel     = rd_sel_q;
   assign bus.step_valid = valid_q;
   assign bus.step_value = value_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with short phases (ON=4, OFF=2).
module tb_seq_player;
   import seq_pkg::*;

   typedef struct packed {
      logic [3:0] rd_sel;
      logic       valid;
      logic [2:0] value;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct {
      logic       start;
      logic       stop;
      logic [4:0] length;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] regfile [16];
   vec_t vecs[$];
   int n_pass  = 0;
   int n_total = 0;

   seq_player_if bus ();

   seq_player #(
      .ON_CYCLES  (4),
      .OFF_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.rd_data = regfile[bus.rd_sel];

   function automatic out_t sample();
      out_t o;
      o.rd_sel = bus.rd_sel;
      o.valid  = bus.step_valid;
      o.value  = bus.step_value;
      o.busy   = bus.busy;
      o.done   = bus.done;
      return o;
   endfunction

   function automatic out_t mk(input int rs, input int v, input int val, input int b, input int d);
      out_t o;
      o.rd_sel = 4'(rs);
      o.valid  = 1'(v);
      o.value  = 3'(val);
      o.busy   = 1'(b);
      o.done   = 1'(d);
      return o;
   endfunction

   task automatic add(input int s, input int p, input int l,
                      input int rs, input int v, input int val, input int b, input int d);
      vec_t t;
      t.start  = 1'(s);
      t.stop   = 1'(p);
      t.length = 5'(l);
      t.exp    = mk(rs, v, val, b, d);
      vecs.push_back(t);
   endtask

   task automatic step(input logic s, input logic p, input logic [4:0] l);
      bus.start  = s;
      bus.stop   = p;
      bus.length = l;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t got, input out_t exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got rd_sel=%0d valid=%0b value=%0d busy=%0b done=%0b, want rd_sel=%0d valid=%0b value=%0d busy=%0b done=%0b",
                    name, got.rd_sel, got.valid, got.value, got.busy, got.done,
                    exp.rd_sel, exp.valid, exp.value, exp.busy, exp.done);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, got, exp);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regfile[i] = 3'd0;
      regfile[0] = 3'd5;
      regfile[1] = 3'd2;
      regfile[2] = 3'd7;

      // length=3 playback, with start re-pulses and length changes mid-play
      add(1, 0, 3, 0, 0, 0, 1, 0);
      add(0, 0, 3, 0, 1, 5, 1, 0);
      add(0, 0, 3, 0, 1, 5, 1, 0);
      add(1, 0, 0, 0, 1, 5, 1, 0);
      add(0, 0, 0, 0, 1, 5, 1, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(1, 0, 20, 1, 1, 2, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 20, 1, 1, 2, 1, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 3, 1, 0, 0, 1, 0);
      add(0, 0, 3, 2, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 3, 2, 1, 7, 1, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 3, 2, 0, 0, 1, 0);
      add(0, 0, 3, 2, 0, 0, 0, 1);
      add(0, 0, 3, 2, 0, 0, 0, 0);
      // length=0: immediate done, never busy
      add(1, 0, 0, 2, 0, 0, 0, 1);
      add(0, 0, 0, 2, 0, 0, 0, 0);
      add(0, 0, 0, 2, 0, 0, 0, 0);
      // start and stop together in IDLE
      add(1, 1, 3, 2, 0, 0, 0, 0);
      add(0, 0, 3, 2, 0, 0, 0, 0);

      bus.start = 1'b0; bus.stop = 1'b0; bus.length = 5'd0;
      rst = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      check("reset", sample(), mk(0, 0, 0, 0, 0));
      rst = 1'b0;
      step(0, 0, 0);
      check("idle_after_reset", sample(), mk(0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         step(vecs[i].start, vecs[i].stop, vecs[i].length);
         check($sformatf("vec%0d", i), sample(), vecs[i].exp);
      end

      // length=20 clamps to 16 steps
      begin
         int ndone = 0, done_at = -1, steps = 0, max_sel = 0, zero_again = 0;
         logic prev_valid = 1'b0, seen_nz = 1'b0;
         step(1, 0, 20);
         for (int c = 1; c <= 130; c++) begin
            step(0, 0, 20);
            if (bus.done) begin ndone++; done_at = c; end
            if (bus.step_valid && !prev_valid) steps++;
            prev_valid = bus.step_valid;
            if (int'(bus.rd_sel) > max_sel) max_sel = int'(bus.rd_sel);
            if (bus.rd_sel != 4'd0) seen_nz = 1'b1;
            else if (seen_nz) zero_again++;
         end
         check_int("len20_done_count", ndone, 1);
         check_int("len20_done_cycle", done_at, 112);
         check_int("len20_steps", steps, 16);
         check_int("len20_max_rd_sel", max_sel, 15);
         check_int("len20_rd_sel_wrap", zero_again, 0);
      end

      // stop during second ON phase, then replay from index 0
      begin
         int ndone = 0, nbusy = 0;
         step(1, 0, 3);
         for (int i = 0; i < 9; i++) step(0, 0, 3);
         check("stop_pre", sample(), mk(1, 1, 2, 1, 0));
         step(0, 1, 3);
         check("stop_idle", sample(), mk(1, 0, 0, 0, 0));
         for (int i = 0; i < 25; i++) begin
            step(0, 0, 3);
            if (bus.done) ndone++;
            if (bus.busy) nbusy++;
         end
         check_int("stop_no_done", ndone, 0);
         check_int("stop_stays_idle", nbusy, 0);
         step(1, 0, 3);
         check("replay_fetch", sample(), mk(0, 0, 0, 1, 0));
         step(0, 0, 3);
         check("replay_on", sample(), mk(0, 1, 5, 1, 0));
      end

      // reset mid-playback
      begin
         int ndone = 0;
         for (int i = 0; i < 3; i++) step(0, 0, 3);
         rst = 1'b1;
         step(0, 0, 3);
         check("midplay_reset", sample(), mk(0, 0, 0, 0, 0));
         rst = 1'b0;
         for (int i = 0; i < 25; i++) begin
            step(0, 0, 3);
            if (bus.done || bus.busy) ndone++;
         end
         check_int("midplay_reset_quiet", ndone, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
